// File: rtl/vxe_mem_pkg.sv
// Shared definitions for the VxEngine memory responder: default widths,
// request opcodes, response payload type and a byte-enable helper.
package vxe_mem_pkg;

   localparam int unsigned ADDR_W_DEF = 10;
   localparam int unsigned DATA_W_DEF = 64;
   localparam int unsigned ID_W_DEF   = 6;

   // Request opcode carried on i_rq_wr
   localparam logic RQ_RD = 1'b0;
   localparam logic RQ_WR = 1'b1;

   // Read response payload at the default widths
   typedef struct packed {
      logic [ID_W_DEF-1:0]   id;
      logic [DATA_W_DEF-1:0] data;
   } rsp_t;

   // Expand per-byte enables into a per-bit mask
   function automatic logic [DATA_W_DEF-1:0] ben_mask(input logic [DATA_W_DEF/8-1:0] ben);
      logic [DATA_W_DEF-1:0] m;
      m = '0;
      for (int unsigned b = 0; b < DATA_W_DEF/8; b++) begin
         m[b*8 +: 8] = {8{ben[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/vxe_mem_rsp_fifo.sv
// Synchronous response FIFO with a registered head word and registered
// empty/full flags. The head holds its last value while the FIFO is empty.
module vxe_mem_rsp_fifo #(
   parameter int unsigned W     = 70,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic         empty_o,
   output logic         full_o
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned PTRW = AW + 1;

   logic [W-1:0]    mem_q [DEPTH];
   logic [PTRW-1:0] wptr_q, wptr_d;
   logic [PTRW-1:0] rptr_q, rptr_d;
   logic [W-1:0]    head_q, head_d;
   logic            empty_q, empty_d;
   logic            full_q, full_d;
   logic            do_push, do_pop;

   assign do_pop  = pop_i & ~empty_q;
   assign do_push = push_i & (~full_q | do_pop);

   // Next pointers, flags and head word. A push into the slot that becomes
   // the head is forwarded straight into the head register.
   always_comb begin
      wptr_d  = wptr_q + PTRW'(do_push);
      rptr_d  = rptr_q + PTRW'(do_pop);
      empty_d = (wptr_d == rptr_d);
      full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
      head_d  = head_q;
      if (!empty_d) begin
         if (do_push && (wptr_q[AW-1:0] == rptr_d[AW-1:0])) begin
            head_d = data_i;
         end else begin
            head_d = mem_q[rptr_d[AW-1:0]];
         end
      end
   end

   // Control state: pointers, flags and head register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         head_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         head_q  <= head_d;
      end
   end

   // Storage array, not reset
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wptr_q[AW-1:0]] <= data_i;
      end
   end

   assign data_o  = head_q;
   assign empty_o = empty_q;
   assign full_o  = full_q;

endmodule

// File: rtl/vxe_mem_responder.sv
// Memory-side responder: word-addressed RAM with byte-enable writes, a
// fixed-latency read pipeline and a credit-protected in-order response FIFO.
module vxe_mem_responder
   import vxe_mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned ID_W       = ID_W_DEF,
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                i_rq_vld,
   output logic                o_rq_rdy,
   input  logic                i_rq_wr,
   input  logic [ADDR_W-1:0]   i_rq_addr,
   input  logic [ID_W-1:0]     i_rq_id,
   input  logic [DATA_W-1:0]   i_rq_data,
   input  logic [DATA_W/8-1:0] i_rq_ben,
   output logic                o_rs_vld,
   input  logic                i_rs_rdy,
   output logic [ID_W-1:0]     o_rs_id,
   output logic [DATA_W-1:0]   o_rs_data
);

   localparam int unsigned BE_W    = DATA_W / 8;
   localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned PW      = ID_W + DATA_W;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   logic              rdy_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              rq_acc, rd_acc, wr_acc;
   logic              rs_vld, rs_hs;

   logic              wr_vld_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic [BE_W-1:0]   wr_ben_q;

   logic [DATA_W-1:0] rd_word;

   logic [LATENCY-1:0] pv_q;
   logic [PW-1:0]      pp_q [LATENCY];

   logic              pipe_push;
   logic [PW-1:0]     fifo_dout;
   logic              fifo_empty, fifo_full;

   assign rq_acc = i_rq_vld & rdy_q;
   assign wr_acc = rq_acc & (i_rq_wr == RQ_WR);
   assign rd_acc = rq_acc & (i_rq_wr == RQ_RD);
   assign rs_hs  = rs_vld & i_rs_rdy;

   // Accepted writes are staged one cycle before reaching the RAM. This stage
   // has no reset so a write accepted just before nrst falls still lands.
   always_ff @(posedge clk) begin
      wr_vld_q  <= wr_acc;
      wr_addr_q <= i_rq_addr;
      wr_data_q <= i_rq_data;
      wr_ben_q  <= i_rq_ben;
   end

   // RAM commit of the staged write, byte lane by byte lane
   always_ff @(posedge clk) begin
      if (wr_vld_q) begin
         for (int unsigned b = 0; b < BE_W; b++) begin
            if (wr_ben_q[b]) begin
               mem_q[wr_addr_q][b*8 +: 8] <= wr_data_q[b*8 +: 8];
            end
         end
      end
   end

   // RAM read with write-first bypass of the still-staged write, so a read
   // on the cycle right after a write to the same word sees the new bytes.
   always_comb begin
      rd_word = mem_q[i_rq_addr];
      if (wr_vld_q && (wr_addr_q == i_rq_addr)) begin
         for (int unsigned b = 0; b < BE_W; b++) begin
            if (wr_ben_q[b]) begin
               rd_word[b*8 +: 8] = wr_data_q[b*8 +: 8];
            end
         end
      end
   end

   // Read pipeline valid bits; cleared on reset so in-flight reads vanish
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pv_q <= '0;
      end else begin
         pv_q[0] <= rd_acc;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            pv_q[i] <= pv_q[i-1];
         end
      end
   end

   // Read pipeline payload {id, data}, not reset
   always_ff @(posedge clk) begin
      pp_q[0] <= {i_rq_id, rd_word};
      for (int unsigned i = 1; i < LATENCY; i++) begin
         pp_q[i] <= pp_q[i-1];
      end
   end

   assign pipe_push = pv_q[LATENCY-1];

   // Credit counter next value: reads in flight plus reads queued
   always_comb begin
      cnt_d = cnt_q;
      unique case ({rd_acc, rs_hs})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Credit counter and registered request ready
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q <= '0;
         rdy_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         rdy_q <= (cnt_d < DEPTH_C);
      end
   end

   vxe_mem_rsp_fifo #(
      .W     (PW),
      .DEPTH (FIFO_DEPTH)
   ) u_rsp_fifo (
      .clk_i   (clk),
      .rst_ni  (nrst),
      .push_i  (pipe_push),
      .data_i  (pp_q[LATENCY-1]),
      .pop_i   (i_rs_rdy),
      .data_o  (fifo_dout),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign rs_vld               = ~fifo_empty;
   assign o_rs_vld             = rs_vld;
   assign {o_rs_id, o_rs_data} = fifo_dout;
   assign o_rq_rdy             = rdy_q;

   // Credits must keep the FIFO from ever overflowing
   always_ff @(posedge clk) begin
      if (nrst) begin
         assert (!(pipe_push && fifo_full && !rs_hs));
         assert (cnt_q <= DEPTH_C);
      end
   end

endmodule

// File: tb/tb_vxe_mem_responder.sv
// Directed bench for vxe_mem_responder with a response scoreboard.
module tb_vxe_mem_responder;
   import vxe_mem_pkg::*;

   logic        clk = 1'b0;
   logic        nrst;
   logic        rq_vld, rq_rdy, rq_wr;
   logic [9:0]  rq_addr;
   logic [5:0]  rq_id;
   logic [63:0] rq_data;
   logic [7:0]  rq_ben;
   logic        rs_vld, rs_rdy;
   logic [5:0]  rs_id;
   logic [63:0] rs_data;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned n_rsp   = 0;
   logic        last_acc = 1'b0;
   rsp_t        exp_q [$];
   logic [63:0] mdl [int unsigned];

   vxe_mem_responder #(
      .ADDR_W     (10),
      .DATA_W     (64),
      .ID_W       (6),
      .LATENCY    (2),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .nrst      (nrst),
      .i_rq_vld  (rq_vld),
      .o_rq_rdy  (rq_rdy),
      .i_rq_wr   (rq_wr),
      .i_rq_addr (rq_addr),
      .i_rq_id   (rq_id),
      .i_rq_data (rq_data),
      .i_rq_ben  (rq_ben),
      .o_rs_vld  (rs_vld),
      .i_rs_rdy  (rs_rdy),
      .o_rs_id   (rs_id),
      .o_rs_data (rs_data)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: account for the handshakes the next posedge will
   // perform, then advance to the following negedge.
   task automatic cyc();
      rsp_t        e;
      logic [63:0] m, old;
      last_acc = rq_vld && rq_rdy && nrst;
      if (rs_vld && rs_rdy && nrst) begin
         n_rsp++;
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_id", rs_id, e.id);
            chk("sb_data", rs_data, e.data);
         end
      end
      if (last_acc) begin
         if (rq_wr) begin
            m   = ben_mask(rq_ben);
            old = mdl.exists(rq_addr) ? mdl[rq_addr] : 64'h0;
            mdl[rq_addr] = (old & ~m) | (rq_data & m);
         end else begin
            e.id   = rq_id;
            e.data = mdl[rq_addr];
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic w, input logic [9:0] a, input logic [5:0] id,
                       input logic [63:0] d, input logic [7:0] be);
      int unsigned g = 0;
      rq_vld = 1'b1; rq_wr = w; rq_addr = a; rq_id = id; rq_data = d; rq_ben = be;
      do begin
         cyc();
         g++;
      end while (!last_acc && g < 50);
      if (!last_acc) chk("send_timeout", 0, 1);
      rq_vld = 1'b0;
   endtask

   task automatic wait_vld(input string tag);
      int unsigned g = 0;
      while (!rs_vld && g < 20) begin
         cyc();
         g++;
      end
      chk(tag, rs_vld, 1);
   endtask

   task automatic drain();
      int unsigned g = 0;
      while (exp_q.size() != 0 && g < 50) begin
         cyc();
         g++;
      end
      chk("drain", exp_q.size(), 0);
   endtask

   initial begin
      int unsigned nxt, stalls, n0;
      logic [5:0]  hold_id;
      logic [63:0] hold_data;

      nrst = 1'b0; rq_vld = 1'b0; rq_wr = 1'b0; rq_addr = '0; rq_id = '0;
      rq_data = '0; rq_ben = '0; rs_rdy = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("rst_rq_rdy", rq_rdy, 0);
      chk("rst_rs_vld", rs_vld, 0);
      chk("rst_rs_id", rs_id, 0);
      chk("rst_rs_data", rs_data, 0);
      nrst = 1'b1;
      cyc();
      chk("rdy_after_rst", rq_rdy, 1);

      // Basic write then read with latency check
      send(RQ_WR, 10'h005, 6'd0, 64'h1122334455667788, 8'hFF);
      send(RQ_RD, 10'h005, 6'd3, 64'h0, 8'h00);
      chk("lat_0", rs_vld, 0);
      cyc();
      chk("lat_1", rs_vld, 0);
      cyc();
      chk("lat_2", rs_vld, 1);
      chk("basic_id", rs_id, 6'd3);
      chk("basic_data", rs_data, 64'h1122334455667788);
      drain();

      // Byte enables, back-to-back so the partial write also uses the bypass
      send(RQ_WR, 10'h010, 6'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      send(RQ_WR, 10'h010, 6'd0, 64'h0, 8'h0F);
      send(RQ_RD, 10'h010, 6'd7, 64'h0, 8'h00);
      wait_vld("ben_vld");
      chk("ben_data", rs_data, 64'hFFFFFFFF00000000);
      drain();

      // Write immediately followed by read of the same word
      send(RQ_WR, 10'h020, 6'd0, 64'hA5A5A5A5A5A5A5A5, 8'hFF);
      send(RQ_RD, 10'h020, 6'd9, 64'h0, 8'h00);
      wait_vld("byp_vld");
      chk("byp_id", rs_id, 6'd9);
      chk("byp_data", rs_data, 64'hA5A5A5A5A5A5A5A5);
      drain();

      // Backpressure: only FIFO_DEPTH reads accepted while responses stall
      for (int unsigned i = 0; i < 6; i++) begin
         send(RQ_WR, 10'(10'h100 + i), 6'd0, 64'h0101010101010101 * 64'(i + 1), 8'hFF);
      end
      rs_rdy = 1'b0;
      nxt = 0;
      for (int unsigned c = 0; c < 10; c++) begin
         rq_vld = 1'b1; rq_wr = RQ_RD; rq_addr = 10'(10'h100 + nxt); rq_id = 6'(nxt);
         cyc();
         if (last_acc) nxt++;
      end
      chk("bp_accepted", nxt, 4);
      chk("bp_rdy_low", rq_rdy, 0);
      chk("bp_head_id", rs_id, 0);
      hold_id = rs_id; hold_data = rs_data;
      cyc();
      chk("bp_hold_vld", rs_vld, 1);
      chk("bp_hold_id", rs_id, hold_id);
      chk("bp_hold_data", rs_data, hold_data);
      rs_rdy = 1'b1;
      for (int unsigned c = 0; c < 30 && nxt < 6; c++) begin
         rq_vld = 1'b1; rq_wr = RQ_RD; rq_addr = 10'(10'h100 + nxt); rq_id = 6'(nxt);
         cyc();
         if (last_acc) nxt++;
      end
      rq_vld = 1'b0;
      chk("bp_all_accepted", nxt, 6);
      drain();

      // Streaming: a read every cycle, one response every cycle
      stalls = 0;
      n0 = n_rsp;
      for (int unsigned i = 0; i < 20; i++) begin
         rq_vld = 1'b1; rq_wr = RQ_RD; rq_addr = 10'(10'h100 + (i % 6)); rq_id = 6'(i);
         cyc();
         if (!last_acc) stalls++;
      end
      rq_vld = 1'b0;
      chk("stream_stalls", stalls, 0);
      chk("stream_rsp_cnt", n_rsp - n0, 17);
      chk("stream_rdy", rq_rdy, 1);
      drain();

      // Reset with reads outstanding and a write just accepted
      rs_rdy = 1'b0;
      send(RQ_RD, 10'h005, 6'd10, 64'h0, 8'h00);
      send(RQ_RD, 10'h010, 6'd11, 64'h0, 8'h00);
      send(RQ_RD, 10'h020, 6'd12, 64'h0, 8'h00);
      send(RQ_WR, 10'h030, 6'd0, 64'h0123456789ABCDEF, 8'hFF);
      chk("pre_rst_vld", rs_vld, 1);
      nrst = 1'b0;
      #1;
      chk("rst_async_vld", rs_vld, 0);
      chk("rst_async_rdy", rq_rdy, 0);
      chk("rst_async_data", rs_data, 0);
      exp_q.delete();
      @(negedge clk);
      cyc();
      chk("rst_hold_vld", rs_vld, 0);
      nrst = 1'b1;
      rs_rdy = 1'b1;
      for (int unsigned c = 0; c < 8; c++) cyc();
      chk("post_rst_vld", rs_vld, 0);
      chk("post_rst_rdy", rq_rdy, 1);
      send(RQ_RD, 10'h005, 6'd1, 64'h0, 8'h00);
      wait_vld("post_rst_rd_vld");
      chk("post_rst_rd_data", rs_data, 64'h1122334455667788);
      drain();
      send(RQ_RD, 10'h030, 6'd2, 64'h0, 8'h00);
      wait_vld("post_rst_wr_vld");
      chk("post_rst_wr_data", rs_data, 64'h0123456789ABCDEF);
      drain();
      for (int unsigned c = 0; c < 4; c++) cyc();
      chk("final_sb_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vxe_mem_responder.md
Name: vxe_mem_responder

Overview:
Memory-side responder for the VxEngine memory request interface, i.e. the slave end of the channel that vxe_top drives as initiator. It accepts read/write requests, serves them from an internal word-addressed RAM, and returns read responses in order after a fixed pipeline latency through a credit-protected response FIFO. It is used in tb_vxe_top and in FPGA bring-up builds as the memory stand-in.

Parameters:
ADDR_W, 10, word address width; RAM holds 2**ADDR_W words
DATA_W, 64, data word width; must be a multiple of 8
ID_W, 6, request tag width, echoed in the response
LATENCY, 2, cycles from read accept to FIFO write; legal range 1..8
FIFO_DEPTH, 4, response FIFO entries; power of two, at least 2

Ports:
clk  in  1  clock, rising edge
nrst  in  1  asynchronous active-low reset
i_rq_vld  in  1  request valid
o_rq_rdy  out  1  request ready
i_rq_wr  in  1  1 = write, 0 = read
i_rq_addr  in  ADDR_W  word address
i_rq_id  in  ID_W  request tag
i_rq_data  in  DATA_W  write data
i_rq_ben  in  DATA_W/8  write byte enables
o_rs_vld  out  1  read response valid
i_rs_rdy  in  1  response ready
o_rs_id  out  ID_W  tag of the read being answered
o_rs_data  out  DATA_W  read data

Behaviour:
- Reset (nrst low, asynchronous): o_rq_rdy=0, o_rs_vld=0, o_rs_id=0, o_rs_data=0. FIFO is emptied, pipeline valids are cleared and the credit counter is set to 0. RAM contents are not reset.
- First cycle after reset release: o_rq_rdy=1.
- Request handshake: a request is accepted on a rising edge with i_rq_vld & o_rq_rdy.
  - o_rq_rdy is a function of registered state only. It never depends on any i_rq_* input.
- Credits: counter cnt counts reads in the pipeline plus reads in the FIFO.
  - Accepting a read increments cnt. A response handshake (o_rs_vld & i_rs_rdy) decrements cnt.
  - When both happen in the same cycle, cnt is unchanged.
  - o_rq_rdy = (cnt < FIFO_DEPTH). Writes also stall while rdy=0. This keeps ordering simple.
- Write: on accept, each byte lane b with i_rq_ben[b]=1 is written at i_rq_addr. Other lanes are unchanged. No response is generated.
- Read: on accept, the RAM is read at i_rq_addr. The data and i_rq_id enter a LATENCY-stage shift pipeline and are pushed into the FIFO LATENCY cycles after accept.
  - With LATENCY=1 and an empty FIFO, o_rs_vld rises on the edge after the accept edge.
- Ordering: requests take effect in accept order.
  - A read accepted after a write to the same address returns the new data, including back-to-back on consecutive cycles. Write-first bypass is required.
  - Responses return in read-accept order.
- Pipeline never stalls. Credits guarantee the FIFO has room for every in-flight read, so FIFO overflow is impossible. An assertion flags a push into a full FIFO.
- Response: o_rs_vld = FIFO non-empty. o_rs_id and o_rs_data are the FIFO head and stay stable while o_rs_vld & !i_rs_rdy.
  - When the FIFO is empty, o_rs_data and o_rs_id hold their last value.
- Simultaneous FIFO push and pop when full or empty:
  - Full: legal. The pop frees space in the same cycle.
  - Empty: a push to an empty FIFO is visible as o_rs_vld the following cycle. There is no fall-through.
- Reset asserted mid-operation: all outstanding reads are dropped with no responses. Writes already accepted remain in RAM.
- Address arithmetic: i_rq_addr indexes the RAM directly. There is no wrap or error path, since the width defines the range.
- The FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- cnt is log2(FIFO_DEPTH)+1 bits and never exceeds FIFO_DEPTH.

Decomposition:
- Shared package vxe_mem_pkg holds:
  - the default ADDR_W/DATA_W/ID_W constants;
  - a typedef for the response payload struct {id, data};
  - the request opcode constants RQ_RD=0 and RQ_WR=1.
- One natural sub-module: vxe_mem_rsp_fifo, a synchronous FIFO with registered outputs, async active-low reset, push/pop/full/empty and a payload parameter. The top contains the RAM, the byte-enable write, the bypass, the latency pipeline and the credit counter.

Test Plan:
- Basic write/read: write addr 0x005 data 0x1122334455667788 with ben=0xFF, then read addr 0x005 with id=3 -> after LATENCY=2 cycles, o_rs_vld=1, o_rs_id=3, o_rs_data=0x1122334455667788.
- Byte enables: write 0xFFFF_FFFF_FFFF_FFFF, then write 0x0 with ben=0x0F, then read -> data 0xFFFFFFFF00000000.
- Back-to-back write then read to the same address on consecutive cycles, data 0xA5A5... -> response 0xA5A5... (bypass).
- Backpressure: i_rs_rdy=0, issue 6 reads with ids 0..5 -> 4 accepted, o_rq_rdy=0 after the 4th. Release i_rs_rdy -> ids 0,1,2,3 in order, then 4 and 5 are accepted and returned.
- Steady streaming: i_rs_rdy=1, continuous reads -> one response per cycle, o_rq_rdy stays 1, cnt is unchanged on simultaneous accept and pop.
- Reset mid-operation: 3 reads outstanding, pulse nrst low for 2 cycles -> o_rs_vld=0 immediately and after release, no stale responses appear, and the earlier written data still reads back correctly.
